// File: rtl/pe_cluster_if.sv
// pe_cluster_if: weight/activation inputs and per-PE int8 results of the PE cluster.
interface pe_cluster_if;
  logic [31:0] Weight_0, Weight_1, Weight_2, Weight_3;
  logic [31:0] Weight_4, Weight_5, Weight_6, Weight_7;
  logic [31:0] Weight_8, Weight_9, Weight_10, Weight_11;
  logic [31:0] Weight_12, Weight_13, Weight_14, Weight_15;
  logic [31:0] IFM;
  logic [15:0] PE_reset;
  logic [15:0] PE_finish;
  logic [7:0] OFM_0, OFM_1, OFM_2, OFM_3;
  logic [7:0] OFM_4, OFM_5, OFM_6, OFM_7;
  logic [7:0] OFM_8, OFM_9, OFM_10, OFM_11;
  logic [7:0] OFM_12, OFM_13, OFM_14, OFM_15;
  logic [15:0] valid;
  modport master (
    output Weight_0, Weight_1, Weight_2, Weight_3, Weight_4, Weight_5, Weight_6, Weight_7,
    output Weight_8, Weight_9, Weight_10, Weight_11, Weight_12, Weight_13, Weight_14, Weight_15,
    output IFM, PE_reset, PE_finish,
    input OFM_0, OFM_1, OFM_2, OFM_3, OFM_4, OFM_5, OFM_6, OFM_7,
    input OFM_8, OFM_9, OFM_10, OFM_11, OFM_12, OFM_13, OFM_14, OFM_15,
    input valid
  );
  modport slave (
    input Weight_0, Weight_1, Weight_2, Weight_3, Weight_4, Weight_5, Weight_6, Weight_7,
    input Weight_8, Weight_9, Weight_10, Weight_11, Weight_12, Weight_13, Weight_14, Weight_15,
    input IFM, PE_reset, PE_finish,
    output OFM_0, OFM_1, OFM_2, OFM_3, OFM_4, OFM_5, OFM_6, OFM_7,
    output OFM_8, OFM_9, OFM_10, OFM_11, OFM_12, OFM_13, OFM_14, OFM_15,
    output valid
  );
endinterface

// File: rtl/pe_cluster.sv
// pe_cluster: 16 int8 dot-product PEs with saturating accumulators and int8 output on finish.
module pe_cluster #(
  parameter int ACC_W = 32,
  parameter int OUT_SHIFT = 0
) (
  input logic clk,
  input logic reset_n,
  pe_cluster_if.slave bus
);
  localparam int NUM_PE = 16;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [31:0] w [NUM_PE];
  logic [7:0] ofm [NUM_PE];
  logic vld [NUM_PE];
  assign w[0] = bus.Weight_0;
  assign w[1] = bus.Weight_1;
  assign w[2] = bus.Weight_2;
  assign w[3] = bus.Weight_3;
  assign w[4] = bus.Weight_4;
  assign w[5] = bus.Weight_5;
  assign w[6] = bus.Weight_6;
  assign w[7] = bus.Weight_7;
  assign w[8] = bus.Weight_8;
  assign w[9] = bus.Weight_9;
  assign w[10] = bus.Weight_10;
  assign w[11] = bus.Weight_11;
  assign w[12] = bus.Weight_12;
  assign w[13] = bus.Weight_13;
  assign w[14] = bus.Weight_14;
  assign w[15] = bus.Weight_15;
  assign bus.OFM_0 = ofm[0];
  assign bus.OFM_1 = ofm[1];
  assign bus.OFM_2 = ofm[2];
  assign bus.OFM_3 = ofm[3];
  assign bus.OFM_4 = ofm[4];
  assign bus.OFM_5 = ofm[5];
  assign bus.OFM_6 = ofm[6];
  assign bus.OFM_7 = ofm[7];
  assign bus.OFM_8 = ofm[8];
  assign bus.OFM_9 = ofm[9];
  assign bus.OFM_10 = ofm[10];
  assign bus.OFM_11 = ofm[11];
  assign bus.OFM_12 = ofm[12];
  assign bus.OFM_13 = ofm[13];
  assign bus.OFM_14 = ofm[14];
  assign bus.OFM_15 = ofm[15];
  always_comb for (int k = 0; k < NUM_PE; k++) bus.valid[k] = vld[k];
  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    logic signed [15:0] p [4];
    logic signed [17:0] prod;
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W-1:0] acc, sum, shf;
    logic [7:0] o;
    always_comb begin
      for (int b = 0; b < 4; b++)
        p[b] = 16'($signed(w[i][8*b+:8])) * 16'($signed(bus.IFM[8*b+:8]));
      prod = 18'(p[0]) + 18'(p[1]) + 18'(p[2]) + 18'(p[3]);
      wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
      // one extra bit exposes overflow; clamp instead of wrapping
      sum = (wide[ACC_W] != wide[ACC_W-1]) ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
      shf = sum >>> OUT_SHIFT;
      o = (shf > 127) ? 8'h7f : (shf < -128) ? 8'h80 : shf[7:0];
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        acc <= '0;
        ofm[i] <= 8'h00;
        vld[i] <= 1'b0;
      end else if (bus.PE_reset[i]) begin
        acc <= '0;
        vld[i] <= 1'b0;
      end else if (bus.PE_finish[i]) begin
        acc <= '0;
        ofm[i] <= o;
        vld[i] <= 1'b1;
      end else begin
        acc <= sum;
        vld[i] <= 1'b0;
      end
  end
endmodule

// File: tb/tb_pe_cluster.sv
// tb_pe_cluster: directed vectors and hand-built sequences for the PE cluster.
module tb_pe_cluster;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  pe_cluster_if bus();
  pe_cluster dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [31:0] wt [16];
  logic [7:0] ofm [16];
  assign bus.Weight_0 = wt[0];
  assign bus.Weight_1 = wt[1];
  assign bus.Weight_2 = wt[2];
  assign bus.Weight_3 = wt[3];
  assign bus.Weight_4 = wt[4];
  assign bus.Weight_5 = wt[5];
  assign bus.Weight_6 = wt[6];
  assign bus.Weight_7 = wt[7];
  assign bus.Weight_8 = wt[8];
  assign bus.Weight_9 = wt[9];
  assign bus.Weight_10 = wt[10];
  assign bus.Weight_11 = wt[11];
  assign bus.Weight_12 = wt[12];
  assign bus.Weight_13 = wt[13];
  assign bus.Weight_14 = wt[14];
  assign bus.Weight_15 = wt[15];
  assign ofm[0] = bus.OFM_0;
  assign ofm[1] = bus.OFM_1;
  assign ofm[2] = bus.OFM_2;
  assign ofm[3] = bus.OFM_3;
  assign ofm[4] = bus.OFM_4;
  assign ofm[5] = bus.OFM_5;
  assign ofm[6] = bus.OFM_6;
  assign ofm[7] = bus.OFM_7;
  assign ofm[8] = bus.OFM_8;
  assign ofm[9] = bus.OFM_9;
  assign ofm[10] = bus.OFM_10;
  assign ofm[11] = bus.OFM_11;
  assign ofm[12] = bus.OFM_12;
  assign ofm[13] = bus.OFM_13;
  assign ofm[14] = bus.OFM_14;
  assign ofm[15] = bus.OFM_15;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [31:0] w;
    logic [31:0] ifm;
    int n;
    logic [7:0] e;
  } vec_t;
  vec_t tv [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rand_in();
    foreach (wt[k]) wt[k] = $urandom;
    bus.IFM = $urandom;
    bus.PE_reset = 16'($urandom);
    bus.PE_finish = 16'($urandom);
  endtask
  initial begin
    tv[0] = '{32'h000000ff, 32'h00000005, 0, 8'hfb};
    tv[1] = '{32'h000000ff, 32'h00000080, 0, 8'h7f};
    tv[2] = '{32'h01010101, 32'h01010101, 2, 8'h0c};
    tv[3] = '{32'h80808080, 32'h7f7f7f7f, 0, 8'h80};
    tv[4] = '{32'h80808080, 32'h80808080, 0, 8'h7f};
    tv[5] = '{32'h00000002, 32'h000000fd, 3, 8'he8};
    tv[6] = '{32'h00000000, 32'h12345678, 1, 8'h00};
    tv[7] = '{32'h0000007f, 32'h00000001, 0, 8'h7f};
    tv[8] = '{32'h00000081, 32'h00000001, 0, 8'h81};
    tv[9] = '{32'hffffffff, 32'h01010101, 4, 8'hec};
    tv[10] = '{32'h00030000, 32'h00f60000, 0, 8'he2};
    tv[11] = '{32'h80808080, 32'h80808080, 32770, 8'h7f};
    tv[12] = '{32'h80808080, 32'h7f7f7f7f, 33030, 8'h80};
    // T1: asynchronous reset with random inputs
    rand_in();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.valid), 32'h0);
    foreach (ofm[k]) chk($sformatf("rst_async_ofm%0d", k), 32'(ofm[k]), 32'h0);
    repeat (3) begin
      rand_in();
      step();
    end
    chk("rst_hold_valid", 32'(bus.valid), 32'h0);
    chk("rst_hold_ofm0", 32'(ofm[0]), 32'h0);
    chk("rst_hold_ofm15", 32'(ofm[15]), 32'h0);
    reset_n = 1'b1;
    // table vectors: clear, accumulate n cycles, then finish all PEs
    for (int i = 0; i < 13; i++) begin
      foreach (wt[k]) wt[k] = tv[i].w;
      bus.IFM = tv[i].ifm;
      bus.PE_reset = 16'hffff;
      bus.PE_finish = 16'h0;
      step();
      bus.PE_reset = 16'h0;
      repeat (tv[i].n) step();
      bus.PE_finish = 16'hffff;
      step();
      bus.PE_finish = 16'h0;
      chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'hffff);
      chk($sformatf("vec%0d_ofm0", i), 32'(ofm[0]), 32'(tv[i].e));
      chk($sformatf("vec%0d_ofm15", i), 32'(ofm[15]), 32'(tv[i].e));
    end
    // T2: ramp, prod_k = 4k over three cycles
    foreach (wt[k]) wt[k] = 32'(k);
    bus.IFM = 32'h01020304;
    bus.PE_reset = 16'hffff;
    step();
    bus.PE_reset = 16'h0;
    repeat (2) step();
    bus.PE_finish = 16'hffff;
    step();
    bus.PE_finish = 16'h0;
    chk("ramp_valid", 32'(bus.valid), 32'hffff);
    foreach (ofm[k]) chk($sformatf("ramp_ofm%0d", k), 32'(ofm[k]), (k <= 10) ? 32'(12 * k) : 32'h7f);
    step();
    chk("ramp_valid_pulse", 32'(bus.valid), 32'h0);
    // T4: reset beats finish
    wt[0] = 32'h1;
    bus.IFM = 32'h3;
    bus.PE_reset = 16'h1;
    step();
    bus.PE_reset = 16'h0;
    bus.PE_finish = 16'h1;
    step();
    bus.PE_finish = 16'h0;
    chk("prio_pre_ofm0", 32'(ofm[0]), 32'h03);
    repeat (2) step();
    bus.PE_reset = 16'h1;
    bus.PE_finish = 16'h1;
    step();
    chk("prio_valid0", 32'(bus.valid[0]), 32'h0);
    chk("prio_ofm0_hold", 32'(ofm[0]), 32'h03);
    bus.PE_reset = 16'h0;
    wt[0] = 32'h5;
    step();
    bus.PE_finish = 16'h0;
    chk("prio_next_valid0", 32'(bus.valid[0]), 32'h1);
    chk("prio_next_ofm0", 32'(ofm[0]), 32'h0f);
    // T5: independent finishes
    foreach (wt[k]) wt[k] = 32'h1;
    bus.IFM = 32'h1;
    bus.PE_reset = 16'hffff;
    step();
    bus.PE_reset = 16'h0;
    step();
    bus.PE_finish = 16'h8001;
    step();
    chk("ind_valid_a", 32'(bus.valid), 32'h8001);
    chk("ind_ofm0_a", 32'(ofm[0]), 32'h02);
    chk("ind_ofm15_a", 32'(ofm[15]), 32'h02);
    bus.PE_finish = 16'h0;
    step();
    chk("ind_valid_gap", 32'(bus.valid), 32'h0);
    bus.PE_finish = 16'h7ffe;
    step();
    bus.PE_finish = 16'h0;
    chk("ind_valid_b", 32'(bus.valid), 32'h7ffe);
    chk("ind_ofm1_b", 32'(ofm[1]), 32'h04);
    chk("ind_ofm14_b", 32'(ofm[14]), 32'h04);
    chk("ind_ofm0_hold", 32'(ofm[0]), 32'h02);
    // T6: reset_n pulse mid-accumulation
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ofm1", 32'(ofm[1]), 32'h0);
    chk("midrst_ofm14", 32'(ofm[14]), 32'h0);
    chk("midrst_valid", 32'(bus.valid), 32'h0);
    reset_n = 1'b1;
    step();
    bus.PE_finish = 16'hffff;
    step();
    bus.PE_finish = 16'h0;
    chk("midrst_after_valid", 32'(bus.valid), 32'hffff);
    chk("midrst_after_ofm1", 32'(ofm[1]), 32'h02);
    chk("midrst_after_ofm0", 32'(ofm[0]), 32'h02);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
